regfile_write_arbiter: RTL

//  Shares the single register-file write port between the in-order writeback unit and a

---
 rtl/regfile_write_arbiter_pkg.sv | 22 ++
 rtl/regfile_write_arbiter_fifo.sv | 86 ++++++++
 rtl/regfile_write_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg
//   Shared definitions for the register-file write arbiter slice: register
//   address width, arbitration state encoding and a small helper that tells
//   whether a destination register is architecturally writable (x0 is not).
// ---------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_PENDING = 2'd1,
    ARB_FORCE   = 2'd2
  } arb_state_e;

  // x0 is hard-wired to zero, so a write to it must never reach the port.
  function automatic logic reg_is_live(input logic [REG_ADDR_W-1:0] r);
    return (r != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_fifo
//   Small buffer for long-latency results waiting for the regfile write port.
//   Every entry carries a valid bit; a younger pipeline write to the same
//   register cancels the buffered result through the clr_en/clr_reg port.
// Ports
//   clock, reset            clock and synchronous active-high reset
//   push, push_reg/data     enqueue one result (caller guarantees not full)
//   pop                     dequeue the head (caller guarantees not empty)
//   clr_en, clr_reg         invalidate every entry targeting clr_reg
//   count                   registered occupancy 0..DEPTH
//   head_valid/reg/data     head entry; head_valid is 0 when empty
// ---------------------------------------------------------------------------
module regfile_write_arbiter_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 2,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_reg,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  output logic [CNT_W-1:0]      count,
  output logic                  head_valid,
  output logic [REG_ADDR_W-1:0] head_reg,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DEPTH-1:0]      valid_r;
  logic [REG_ADDR_W-1:0] reg_mem_r  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];

  // Storage, pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        reg_mem_r[i]  <= {REG_ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_en && (reg_mem_r[i] == clr_reg)) begin
          valid_r[i] <= 1'b0;
        end
      end
      if (pop) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
      end
      // A result arriving in the same cycle as a younger pipeline write to
      // the same register is stored already cancelled; x0 is never live.
      if (push) begin
        reg_mem_r[wr_ptr_r]  <= push_reg;
        data_mem_r[wr_ptr_r] <= push_data;
        valid_r[wr_ptr_r]    <= reg_is_live(push_reg) &&
                                !(clr_en && (clr_reg == push_reg));
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count      = count_r;
  assign head_valid = valid_r[rd_ptr_r] && (count_r != {CNT_W{1'b0}});
  assign head_reg   = reg_mem_r[rd_ptr_r];
  assign head_data  = data_mem_r[rd_ptr_r];

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single regfile write port between the in-order writeback unit
//   (priority) and a long-latency result source. LL results are buffered and
//   drained on idle port cycles; a head that has waited MAX_WAIT cycles is
//   forced through while the pipeline is stalled for one cycle.
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   wb_write/wb_reg/wb_data      pipeline writeback request
//   ll_valid/ll_reg/ll_data      LL result, accepted when ll_ready
//   ll_ready                     buffer has room
//   stall_out                    pipeline freeze during a forced drain
//   write/write_reg/write_data   regfile write port (combinational)
//   report                       trace enable (no effect in this RTL)
// ---------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_write,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ll_valid,
  input  logic [REG_ADDR_W-1:0] ll_reg,
  input  logic [DATA_WIDTH-1:0] ll_data,
  output logic                  ll_ready,
  output logic                  stall_out,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  report
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e            state_r;
  arb_state_e            state_next_s;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [WAIT_W-1:0]     wait_next_s;
  logic [CNT_W-1:0]      count_s;
  logic [CNT_W-1:0]      count_next_s;
  logic                  head_valid_s;
  logic [REG_ADDR_W-1:0] head_reg_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  wb_ok_s;
  logic                  wb_grant_s;
  logic                  ll_grant_s;
  logic                  stall_s;
  logic                  report_unused_s;
  logic [31:0]           core_unused_s;

  assign report_unused_s = report;
  assign core_unused_s   = 32'(CORE);

  assign ll_ready = (count_s != CNT_W'(FIFO_DEPTH));
  assign push_s   = ll_valid && ll_ready;
  assign wb_ok_s  = wb_write && reg_is_live(wb_reg);

  regfile_write_arbiter_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_reg   (ll_reg),
    .push_data  (ll_data),
    .pop        (pop_s),
    .clr_en     (wb_grant_s),
    .clr_reg    (wb_reg),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head_reg   (head_reg_s),
    .head_data  (head_data_s)
  );

  // Grant selection, FIFO pop, wait counter and next state.
  always_comb begin
    wb_grant_s   = 1'b0;
    ll_grant_s   = 1'b0;
    pop_s        = 1'b0;
    stall_s      = 1'b0;
    wait_next_s  = {WAIT_W{1'b0}};
    state_next_s = ARB_IDLE;
    case (state_r)
      ARB_IDLE: begin
        wb_grant_s = wb_ok_s;
      end
      ARB_PENDING: begin
        if (!head_valid_s) begin
          // Cancelled head leaves without using the port.
          pop_s      = (count_s != {CNT_W{1'b0}});
          wb_grant_s = wb_ok_s;
        end else if (wb_ok_s) begin
          wb_grant_s  = 1'b1;
          wait_next_s = wait_cnt_r + WAIT_W'(1);
        end else begin
          pop_s      = 1'b1;
          ll_grant_s = 1'b1;
        end
      end
      ARB_FORCE: begin
        // One entry per visit; head may have been cancelled on the way in.
        stall_s    = 1'b1;
        pop_s      = (count_s != {CNT_W{1'b0}});
        ll_grant_s = head_valid_s;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase

    count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    if (count_next_s == {CNT_W{1'b0}}) begin
      state_next_s = ARB_IDLE;
    end else if ((state_r == ARB_PENDING) && (wait_next_s == WAIT_W'(MAX_WAIT))) begin
      state_next_s = ARB_FORCE;
    end else begin
      state_next_s = ARB_PENDING;
    end
  end

  // Arbitration state and head wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ARB_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_next_s;
    end
  end

  // Write-port mux; nothing reaches the regfile while reset is held.
  always_comb begin
    if (reset) begin
      write      = 1'b0;
      write_reg  = {REG_ADDR_W{1'b0}};
      write_data = {DATA_WIDTH{1'b0}};
    end else if (wb_grant_s) begin
      write      = 1'b1;
      write_reg  = wb_reg;
      write_data = wb_data;
    end else if (ll_grant_s) begin
      write      = 1'b1;
      write_reg  = head_reg_s;
      write_data = head_data_s;
    end else begin
      write      = 1'b0;
      write_reg  = {REG_ADDR_W{1'b0}};
      write_data = {DATA_WIDTH{1'b0}};
    end
  end

  assign stall_out = stall_s && !reset;

endmodule
